// File: rtl/controle_jogo.sv
// Game-flow controller for a two-player battleship: placement turns, shot turns,
// per-player hit counting with a win threshold, and a per-turn idle timeout.
module controle_jogo #(
   parameter int HITS_TO_WIN  = 20,
   parameter int TURN_TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       start,
   input  logic       mode,
   input  logic       place_done,
   input  logic       shot_valid,
   input  logic       shot_hit,
   output logic [1:0] fase,
   output logic       jogador,
   output logic       cpu_turn,
   output logic       place_start,
   output logic       shot_req,
   output logic [4:0] acertos0,
   output logic [4:0] acertos1,
   output logic       timeout,
   output logic       fim,
   output logic       vencedor
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLACE = 2'd1, TURN = 2'd2, OVER = 2'd3} state_t;

   localparam logic [4:0] HITS  = 5'(HITS_TO_WIN);
   localparam logic [7:0] TLAST = 8'(TURN_TIMEOUT - 1);

   state_t     state, state_n;
   logic       jog_q, jog_n;
   logic       mode_q, mode_n;
   logic [4:0] hits0_q, hits0_n, hits1_q, hits1_n;
   logic [7:0] timer_q, timer_n;
   logic       win_q, win_n;
   logic       place_start_q, place_start_n;
   logic       timeout_q, timeout_n;
   logic       cpu_q, cpu_n;
   logic [4:0] cur_hits, new_hits;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         jog_q         <= 1'b0;
         mode_q        <= 1'b0;
         hits0_q       <= '0;
         hits1_q       <= '0;
         timer_q       <= '0;
         win_q         <= 1'b0;
         place_start_q <= 1'b0;
         timeout_q     <= 1'b0;
         cpu_q         <= 1'b0;
      end else begin
         state         <= state_n;
         jog_q         <= jog_n;
         mode_q        <= mode_n;
         hits0_q       <= hits0_n;
         hits1_q       <= hits1_n;
         timer_q       <= timer_n;
         win_q         <= win_n;
         place_start_q <= place_start_n;
         timeout_q     <= timeout_n;
         cpu_q         <= cpu_n;
      end
   end

   // With enable low every register keeps its value and only the pulses drop.
   always_comb begin
      state_n       = state;
      jog_n         = jog_q;
      mode_n        = mode_q;
      hits0_n       = hits0_q;
      hits1_n       = hits1_q;
      timer_n       = timer_q;
      win_n         = win_q;
      place_start_n = 1'b0;
      timeout_n     = 1'b0;
      cur_hits      = jog_q ? hits1_q : hits0_q;
      new_hits      = (cur_hits == HITS) ? cur_hits : cur_hits + 5'd1;
      if (enable) begin
         case (state)
            IDLE: if (start) begin
               mode_n        = mode;
               hits0_n       = '0;
               hits1_n       = '0;
               jog_n         = 1'b0;
               win_n         = 1'b0;
               timer_n       = '0;
               state_n       = PLACE;
               place_start_n = 1'b1;
            end
            PLACE: if (place_done) begin
               if (!jog_q) begin
                  jog_n         = 1'b1;
                  place_start_n = 1'b1;
               end else begin
                  jog_n   = 1'b0;
                  timer_n = '0;
                  state_n = TURN;
               end
            end
            TURN: begin
               // A shot in the expiry cycle takes priority over the timeout.
               if (shot_valid) begin
                  timer_n = '0;
                  if (shot_hit) begin
                     if (jog_q) hits1_n = new_hits;
                     else       hits0_n = new_hits;
                     if (new_hits == HITS) begin
                        state_n = OVER;
                        win_n   = jog_q;
                     end
                  end else begin
                     jog_n = ~jog_q;
                  end
               end else if (timer_q >= TLAST) begin
                  jog_n     = ~jog_q;
                  timeout_n = 1'b1;
                  timer_n   = '0;
               end else begin
                  timer_n = timer_q + 8'd1;
               end
            end
            OVER: if (start) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
      cpu_n = mode_n & jog_n & ((state_n == PLACE) || (state_n == TURN));
   end

   always_comb begin
      fase        = state;
      jogador     = jog_q;
      cpu_turn    = cpu_q;
      place_start = place_start_q;
      shot_req    = (state == TURN);
      acertos0    = hits0_q;
      acertos1    = hits1_q;
      timeout     = timeout_q;
      fim         = (state == OVER);
      vencedor    = win_q;
   end

endmodule

// File: tb/tb_controle_jogo.sv
// Randomized and directed bench for controle_jogo against a behavioural game model.
module tb_controle_jogo;

   localparam int H = 20;
   localparam int T = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       place_done = 1'b0;
   logic       shot_valid = 1'b0;
   logic       shot_hit = 1'b0;
   logic [1:0] fase;
   logic       jogador, cpu_turn, place_start, shot_req, timeout, fim, vencedor;
   logic [4:0] acertos0, acertos1;

   int checks = 0;
   int failures = 0;

   // Behavioural model: phase number, current player, hits per player, idle cycles in turn.
   int m_phase, m_player, m_hits[2], m_winner, m_mode, m_held, m_ps, m_to;

   controle_jogo #(.HITS_TO_WIN(H), .TURN_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode),
      .place_done(place_done), .shot_valid(shot_valid), .shot_hit(shot_hit),
      .fase(fase), .jogador(jogador), .cpu_turn(cpu_turn), .place_start(place_start),
      .shot_req(shot_req), .acertos0(acertos0), .acertos1(acertos1),
      .timeout(timeout), .fim(fim), .vencedor(vencedor)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] obs();
      return {fase, jogador, cpu_turn, place_start, shot_req, acertos0, acertos1,
              timeout, fim, vencedor};
   endfunction

   function automatic logic [18:0] expv();
      logic cpu;
      cpu = (m_phase == 1 || m_phase == 2) && m_mode == 1 && m_player == 1;
      return {2'(m_phase), 1'(m_player), cpu, 1'(m_ps), (m_phase == 2),
              5'(m_hits[0]), 5'(m_hits[1]), 1'(m_to), (m_phase == 3), 1'(m_winner)};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_player = 0; m_hits[0] = 0; m_hits[1] = 0;
      m_winner = 0; m_mode = 0; m_held = 0; m_ps = 0; m_to = 0;
   endtask

   task automatic model_step(input bit st, md, pd, sv, sh, en);
      m_ps = 0;
      m_to = 0;
      if (!en) return;
      if (m_phase == 0 && st) begin
         m_mode = md; m_hits[0] = 0; m_hits[1] = 0; m_player = 0; m_winner = 0;
         m_held = 0; m_phase = 1; m_ps = 1;
      end else if (m_phase == 1 && pd) begin
         if (m_player == 0) begin m_player = 1; m_ps = 1; end
         else begin m_player = 0; m_held = 0; m_phase = 2; end
      end else if (m_phase == 2) begin
         if (sv) begin
            m_held = 0;
            if (sh) begin
               if (m_hits[m_player] < H) m_hits[m_player] += 1;
               if (m_hits[m_player] == H) begin m_phase = 3; m_winner = m_player; end
            end else m_player = 1 - m_player;
         end else if (m_held == T - 1) begin
            m_player = 1 - m_player; m_to = 1; m_held = 0;
         end else m_held += 1;
      end else if (m_phase == 3 && st) m_phase = 0;
   endtask

   // Drive inputs at the falling edge, advance one rising edge, sample 1 ns later.
   task automatic step(input bit st, md, pd, sv, sh, en);
      @(negedge clk);
      start = st; mode = md; place_done = pd; shot_valid = sv; shot_hit = sh; enable = en;
      @(posedge clk);
      model_step(st, md, pd, sv, sh, en);
      #1;
      start = 0; place_done = 0; shot_valid = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      model_reset();
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (obs() !== 19'd0) begin
         failures++; $display("[TB] FAIL reset_state got=%h exp=0", obs());
      end
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (obs() !== 19'd0) begin
         failures++; $display("[TB] FAIL reset_release got=%h exp=0", obs());
      end
   endtask

   task automatic test_pvp_flow();
      step(1, 0, 0, 0, 0, 1);
      checks++;
      if ({fase, place_start, jogador} !== {2'd1, 1'b1, 1'b0}) begin
         failures++; $display("[TB] FAIL pvp_start got=%b exp=0110", {fase, place_start, jogador});
      end
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (place_start !== 1'b0) begin
         failures++; $display("[TB] FAIL pvp_pulse_width got=%b exp=0", place_start);
      end
      step(0, 0, 1, 0, 0, 1);
      checks++;
      if ({fase, jogador, place_start} !== {2'd1, 1'b1, 1'b1}) begin
         failures++; $display("[TB] FAIL pvp_place1 got=%b exp=0111", {fase, jogador, place_start});
      end
      step(0, 0, 1, 0, 0, 1);
      checks++;
      if ({fase, jogador, shot_req} !== {2'd2, 1'b0, 1'b1}) begin
         failures++; $display("[TB] FAIL pvp_turn got=%b exp=1001", {fase, jogador, shot_req});
      end
      checks++;
      if (obs() !== expv()) begin
         failures++; $display("[TB] FAIL pvp_model got=%h exp=%h", obs(), expv());
      end
   endtask

   task automatic test_turn_passing();
      step(0, 0, 0, 1, 1, 1);
      checks++;
      if ({acertos0, jogador} !== {5'd1, 1'b0}) begin
         failures++; $display("[TB] FAIL hit_keeps_turn got=%0d/%0d exp=1/0", acertos0, jogador);
      end
      step(0, 0, 0, 1, 0, 1);
      checks++;
      if ({acertos0, jogador} !== {5'd1, 1'b1}) begin
         failures++; $display("[TB] FAIL miss_passes got=%0d/%0d exp=1/1", acertos0, jogador);
      end
   endtask

   task automatic test_win();
      logic [18:0] snap;
      for (int i = 0; i < H - 1; i++) begin
         step(0, 0, 0, 1, 1, 1);
         checks++;
         if (acertos1 !== 5'(i + 1) || fase !== 2'd2) begin
            failures++; $display("[TB] FAIL hit_count got=%0d fase=%0d exp=%0d fase=2", acertos1, fase, i + 1);
         end
      end
      step(0, 0, 0, 1, 1, 1);
      checks++;
      if ({acertos1, fase, fim, vencedor} !== {5'd20, 2'd3, 1'b1, 1'b1}) begin
         failures++; $display("[TB] FAIL win got=%0d fase=%0d fim=%b venc=%b exp=20/3/1/1",
                              acertos1, fase, fim, vencedor);
      end
      snap = expv();
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 1, 1);
         checks++;
         if (obs() !== snap) begin
            failures++; $display("[TB] FAIL over_hold got=%h exp=%h", obs(), snap);
         end
      end
      step(1, 0, 0, 0, 0, 1);
      checks++;
      if ({fase, fim, acertos0, acertos1} !== {2'd0, 1'b0, 5'd1, 5'd20}) begin
         failures++; $display("[TB] FAIL over_to_idle got=%0d/%b/%0d/%0d exp=0/0/1/20",
                              fase, fim, acertos0, acertos1);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 0, 1);
      for (int i = 0; i < T; i++) begin
         step(0, 0, 0, 0, 0, 1);
         checks++;
         if ({timeout, jogador} !== {(i == T - 1), (i == T - 1)}) begin
            failures++; $display("[TB] FAIL timeout_expiry cycle=%0d got=%b%b exp=%b%b",
                                 i, timeout, jogador, i == T - 1, i == T - 1);
         end
      end
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (timeout !== 1'b0) begin
         failures++; $display("[TB] FAIL timeout_single got=%b exp=0", timeout);
      end
      for (int i = 0; i < T - 2; i++) step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      checks++;
      if ({timeout, jogador} !== 2'b00) begin
         failures++; $display("[TB] FAIL shot_beats_timeout got=%b%b exp=00", timeout, jogador);
      end
      checks++;
      if (obs() !== expv()) begin
         failures++; $display("[TB] FAIL timeout_model got=%h exp=%h", obs(), expv());
      end
   endtask

   task automatic test_cpu_freeze();
      logic [18:0] snap;
      do_reset();
      step(1, 1, 0, 0, 0, 1);
      checks++;
      if (cpu_turn !== 1'b0) begin
         failures++; $display("[TB] FAIL cpu_p0 got=%b exp=0", cpu_turn);
      end
      step(0, 0, 1, 0, 0, 1);
      checks++;
      if ({jogador, cpu_turn} !== 2'b11) begin
         failures++; $display("[TB] FAIL cpu_place got=%b exp=11", {jogador, cpu_turn});
      end
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      checks++;
      if ({fase, jogador, cpu_turn} !== {2'd2, 1'b1, 1'b1}) begin
         failures++; $display("[TB] FAIL cpu_turn_p1 got=%b exp=1011", {fase, jogador, cpu_turn});
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
      snap = expv();
      for (int i = 0; i < 50; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
         checks++;
         if (obs() !== snap) begin
            failures++; $display("[TB] FAIL freeze cycle=%0d got=%h exp=%h", i, obs(), snap);
         end
      end
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, 0, 1);
         checks++;
         if ({timeout, jogador} !== {(i == 5), (i != 5)}) begin
            failures++; $display("[TB] FAIL freeze_timer cycle=%0d got=%b%b exp=%b%b",
                                 i, timeout, jogador, i == 5, i != 5);
         end
      end
   endtask

   task automatic test_async_reset();
      step(0, 0, 0, 1, 1, 1);
      checks++;
      if (fase !== 2'd2) begin
         failures++; $display("[TB] FAIL pre_reset_fase got=%0d exp=2", fase);
      end
      #2;
      reset = 1;
      model_reset();
      #1;
      checks++;
      if (obs() !== 19'd0) begin
         failures++; $display("[TB] FAIL async_reset got=%h exp=0", obs());
      end
      @(negedge clk);
      reset = 0;
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (obs() !== 19'd0) begin
         failures++; $display("[TB] FAIL reset_no_pulse got=%h exp=0", obs());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(99) < 6), 1'($urandom), ($urandom_range(99) < 20),
              ($urandom_range(99) < 25), ($urandom_range(99) < 70), ($urandom_range(99) < 90));
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("[TB] FAIL random cycle=%0d got=%h exp=%h", i, obs(), expv());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_pvp_flow();
      test_turn_passing();
      test_win();
      test_timeout();
      test_cpu_freeze();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
